// File: rtl/cgra_top.sv
// Single-tile CGRA: selects a 16-bit word from pad side S0/S1/S2, applies one configurable
// PE operation and registers the result onto the S0 output pads. Optional macro: JTAG_BYPASS_EN.
module cgra_top #(
  parameter logic [23:0] TILE_ID = 24'h000000
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] config_addr_in,
  input  logic [31:0] config_data_in,
  input  logic        pad_S0_T0_in,  pad_S0_T1_in,  pad_S0_T2_in,  pad_S0_T3_in,
  input  logic        pad_S0_T4_in,  pad_S0_T5_in,  pad_S0_T6_in,  pad_S0_T7_in,
  input  logic        pad_S0_T8_in,  pad_S0_T9_in,  pad_S0_T10_in, pad_S0_T11_in,
  input  logic        pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in,
  input  logic        pad_S1_T0_in,  pad_S1_T1_in,  pad_S1_T2_in,  pad_S1_T3_in,
  input  logic        pad_S1_T4_in,  pad_S1_T5_in,  pad_S1_T6_in,  pad_S1_T7_in,
  input  logic        pad_S1_T8_in,  pad_S1_T9_in,  pad_S1_T10_in, pad_S1_T11_in,
  input  logic        pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in,
  input  logic        pad_S2_T0_in,  pad_S2_T1_in,  pad_S2_T2_in,  pad_S2_T3_in,
  input  logic        pad_S2_T4_in,  pad_S2_T5_in,  pad_S2_T6_in,  pad_S2_T7_in,
  input  logic        pad_S2_T8_in,  pad_S2_T9_in,  pad_S2_T10_in, pad_S2_T11_in,
  input  logic        pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in,
  output logic        pad_S0_T0_out,  pad_S0_T1_out,  pad_S0_T2_out,  pad_S0_T3_out,
  output logic        pad_S0_T4_out,  pad_S0_T5_out,  pad_S0_T6_out,  pad_S0_T7_out,
  output logic        pad_S0_T8_out,  pad_S0_T9_out,  pad_S0_T10_out, pad_S0_T11_out,
  output logic        pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out,
  input  logic        tdi,
  input  logic        tms,
  input  logic        tck,
  input  logic        trst_n,
  output logic        tdo
);

  // T0 is the MSB on every side.
  logic [15:0] s0_word, s1_word, s2_word;
  assign s0_word = {pad_S0_T0_in,  pad_S0_T1_in,  pad_S0_T2_in,  pad_S0_T3_in,
                    pad_S0_T4_in,  pad_S0_T5_in,  pad_S0_T6_in,  pad_S0_T7_in,
                    pad_S0_T8_in,  pad_S0_T9_in,  pad_S0_T10_in, pad_S0_T11_in,
                    pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in};
  assign s1_word = {pad_S1_T0_in,  pad_S1_T1_in,  pad_S1_T2_in,  pad_S1_T3_in,
                    pad_S1_T4_in,  pad_S1_T5_in,  pad_S1_T6_in,  pad_S1_T7_in,
                    pad_S1_T8_in,  pad_S1_T9_in,  pad_S1_T10_in, pad_S1_T11_in,
                    pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in};
  assign s2_word = {pad_S2_T0_in,  pad_S2_T1_in,  pad_S2_T2_in,  pad_S2_T3_in,
                    pad_S2_T4_in,  pad_S2_T5_in,  pad_S2_T6_in,  pad_S2_T7_in,
                    pad_S2_T8_in,  pad_S2_T9_in,  pad_S2_T10_in, pad_S2_T11_in,
                    pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};

  logic [1:0]  in_sel_q;
  logic [3:0]  op_q;
  logic [15:0] k_q;
  logic        out_en_q;
  logic [15:0] result_q;

  logic        cfg_we;
  logic [7:0]  cfg_idx;
  assign cfg_idx = config_addr_in[7:0];
  assign cfg_we  = (config_addr_in != 32'd0) && (config_addr_in[31:8] == TILE_ID);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      in_sel_q <= 2'd0;
      op_q     <= 4'd0;
      k_q      <= 16'd0;
      out_en_q <= 1'b0;
    end else if (cfg_we) begin
      unique case (cfg_idx)
        8'h01:   in_sel_q <= config_data_in[1:0];
        8'h02:   op_q     <= config_data_in[3:0];
        8'h03:   k_q      <= config_data_in[15:0];
        8'h04:   out_en_q <= config_data_in[0];
        default: ;
      endcase
    end
  end

  logic [15:0] operand_a;
  logic [15:0] result_d;

  always_comb begin
    operand_a = 16'd0;
    unique case (in_sel_q)
      2'd0:    operand_a = s0_word;
      2'd1:    operand_a = s1_word;
      2'd2:    operand_a = s2_word;
      default: operand_a = 16'd0;
    endcase
  end

  always_comb begin
    result_d = 16'd0;
    unique case (op_q)
      4'd0:    result_d = operand_a;
      4'd1:    result_d = operand_a + k_q;
      4'd2:    result_d = operand_a - k_q;
      4'd3:    result_d = operand_a * k_q;
      4'd4:    result_d = operand_a << k_q[3:0];
      4'd5:    result_d = operand_a >> k_q[3:0];
      4'd6:    result_d = operand_a & k_q;
      4'd7:    result_d = operand_a | k_q;
      4'd8:    result_d = operand_a ^ k_q;
      default: result_d = 16'd0;
    endcase
  end

  // Captures with the config held before any same-edge write.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) result_q <= 16'd0;
    else           result_q <= result_d;
  end

  logic [15:0] out_word;
  assign out_word = out_en_q ? result_q : 16'd0;

  assign {pad_S0_T0_out,  pad_S0_T1_out,  pad_S0_T2_out,  pad_S0_T3_out,
          pad_S0_T4_out,  pad_S0_T5_out,  pad_S0_T6_out,  pad_S0_T7_out,
          pad_S0_T8_out,  pad_S0_T9_out,  pad_S0_T10_out, pad_S0_T11_out,
          pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out} = out_word;

`ifdef JTAG_BYPASS_EN
  logic bypass_q;
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n)   bypass_q <= 1'b0;
    else if (!tms) bypass_q <= tdi;
  end
  assign tdo = bypass_q;

  logic unused_cfg;
  assign unused_cfg = ^config_data_in[31:16];
`else
  assign tdo = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{config_data_in[31:16], tdi, tms, tck, trst_n};
`endif

endmodule

// File: tb/tb_cgra_top.sv
// Directed, table-driven bench for cgra_top: reset, op table, addressing, same-edge
// config/capture, mid-run reset and the JTAG bypass pin behaviour.
module tb_cgra_top;

  localparam logic [23:0] TILE_ID = 24'h000000;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [31:0] config_addr_in, config_data_in;
  logic [15:0] s0, s1, s2;
  logic [15:0] out_w;
  logic        tdi, tms, tck, trst_n, tdo;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  cgra_top #(.TILE_ID(TILE_ID)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .config_addr_in(config_addr_in), .config_data_in(config_data_in),
    .pad_S0_T0_in(s0[15]), .pad_S0_T1_in(s0[14]), .pad_S0_T2_in(s0[13]), .pad_S0_T3_in(s0[12]),
    .pad_S0_T4_in(s0[11]), .pad_S0_T5_in(s0[10]), .pad_S0_T6_in(s0[9]),  .pad_S0_T7_in(s0[8]),
    .pad_S0_T8_in(s0[7]),  .pad_S0_T9_in(s0[6]),  .pad_S0_T10_in(s0[5]), .pad_S0_T11_in(s0[4]),
    .pad_S0_T12_in(s0[3]), .pad_S0_T13_in(s0[2]), .pad_S0_T14_in(s0[1]), .pad_S0_T15_in(s0[0]),
    .pad_S1_T0_in(s1[15]), .pad_S1_T1_in(s1[14]), .pad_S1_T2_in(s1[13]), .pad_S1_T3_in(s1[12]),
    .pad_S1_T4_in(s1[11]), .pad_S1_T5_in(s1[10]), .pad_S1_T6_in(s1[9]),  .pad_S1_T7_in(s1[8]),
    .pad_S1_T8_in(s1[7]),  .pad_S1_T9_in(s1[6]),  .pad_S1_T10_in(s1[5]), .pad_S1_T11_in(s1[4]),
    .pad_S1_T12_in(s1[3]), .pad_S1_T13_in(s1[2]), .pad_S1_T14_in(s1[1]), .pad_S1_T15_in(s1[0]),
    .pad_S2_T0_in(s2[15]), .pad_S2_T1_in(s2[14]), .pad_S2_T2_in(s2[13]), .pad_S2_T3_in(s2[12]),
    .pad_S2_T4_in(s2[11]), .pad_S2_T5_in(s2[10]), .pad_S2_T6_in(s2[9]),  .pad_S2_T7_in(s2[8]),
    .pad_S2_T8_in(s2[7]),  .pad_S2_T9_in(s2[6]),  .pad_S2_T10_in(s2[5]), .pad_S2_T11_in(s2[4]),
    .pad_S2_T12_in(s2[3]), .pad_S2_T13_in(s2[2]), .pad_S2_T14_in(s2[1]), .pad_S2_T15_in(s2[0]),
    .pad_S0_T0_out(out_w[15]), .pad_S0_T1_out(out_w[14]), .pad_S0_T2_out(out_w[13]),
    .pad_S0_T3_out(out_w[12]), .pad_S0_T4_out(out_w[11]), .pad_S0_T5_out(out_w[10]),
    .pad_S0_T6_out(out_w[9]),  .pad_S0_T7_out(out_w[8]),  .pad_S0_T8_out(out_w[7]),
    .pad_S0_T9_out(out_w[6]),  .pad_S0_T10_out(out_w[5]), .pad_S0_T11_out(out_w[4]),
    .pad_S0_T12_out(out_w[3]), .pad_S0_T13_out(out_w[2]), .pad_S0_T14_out(out_w[1]),
    .pad_S0_T15_out(out_w[0]),
    .tdi(tdi), .tms(tms), .tck(tck), .trst_n(trst_n), .tdo(tdo)
  );

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [3:0]  op;
    logic [15:0] k;
    logic [15:0] a0, a1, a2;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cfg_raw(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk_in);
    config_addr_in = addr;
    config_data_in = data;
    @(negedge clk_in);
    config_addr_in = 32'd0;
    config_data_in = 32'd0;
  endtask

  task automatic cfg_write(input logic [7:0] idx, input logic [31:0] data);
    cfg_raw({TILE_ID, idx}, data);
  endtask

  task automatic tck_pulse();
    #2 tck = 1'b1;
    #2 tck = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] seen;

    vecs[0]  = '{"add",        2'd0, 4'd1,  16'h0003, 16'hFFFF, 16'h0000, 16'h0000, 16'h0002};
    vecs[1]  = '{"sub",        2'd0, 4'd2,  16'h0003, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFC};
    vecs[2]  = '{"shl",        2'd0, 4'd4,  16'h0003, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFF8};
    vecs[3]  = '{"and",        2'd0, 4'd6,  16'h0003, 16'hFFFF, 16'h0000, 16'h0000, 16'h0003};
    vecs[4]  = '{"op12",       2'd0, 4'd12, 16'h0003, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    vecs[5]  = '{"pass_s0",    2'd0, 4'd0,  16'h0003, 16'h1234, 16'h0000, 16'h0000, 16'h1234};
    vecs[6]  = '{"mul_s1",     2'd1, 4'd3,  16'h0003, 16'h0000, 16'h1234, 16'h0000, 16'h369C};
    vecs[7]  = '{"shr_s2",     2'd2, 4'd5,  16'h0004, 16'h0000, 16'h0000, 16'hF0F0, 16'h0F0F};
    vecs[8]  = '{"or",         2'd0, 4'd7,  16'h00FF, 16'h1200, 16'h0000, 16'h0000, 16'h12FF};
    vecs[9]  = '{"xor",        2'd0, 4'd8,  16'hFFFF, 16'h00FF, 16'h0000, 16'h0000, 16'hFF00};
    vecs[10] = '{"const0_add", 2'd3, 4'd1,  16'h0005, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0005};
    vecs[11] = '{"borrow",     2'd0, 4'd2,  16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[12] = '{"shl_k3_0",   2'd0, 4'd4,  16'h0011, 16'h8001, 16'h0000, 16'h0000, 16'h0002};
    vecs[13] = '{"op9",        2'd0, 4'd9,  16'h0011, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    vecs[14] = '{"mul_wrap",   2'd0, 4'd3,  16'h0100, 16'h0101, 16'h0000, 16'h0000, 16'h0100};

    config_addr_in = 32'd0;
    config_data_in = 32'd0;
    tdi = 1'b0; tms = 1'b1; tck = 1'b0; trst_n = 1'b1;

    // Reset for 3 ns with random pads.
    reset_in = 1'b0;
    s0 = 16'($urandom); s1 = 16'($urandom); s2 = 16'($urandom);
    #2;
    check("reset_during", out_w, 16'h0000);
    #1 reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("reset_after_noconfig", out_w, 16'h0000);

    // Doubling via multiply on side S2.
    s2 = 16'h0180;
    cfg_write(8'h01, 32'd2);
    cfg_write(8'h02, 32'd3);
    cfg_write(8'h03, 32'd2);
    check("out_en_gated", out_w, 16'h0000);
    cfg_write(8'h04, 32'd1);
    check("doubling_first", out_w, 16'h0300);
    seen = 16'h0300;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk_in);
      if (out_w !== 16'h0300) seen = out_w;
    end
    check("doubling_hold", seen, 16'h0300);

    for (int i = 0; i < 15; i++) begin
      s0 = vecs[i].a0; s1 = vecs[i].a1; s2 = vecs[i].a2;
      cfg_write(8'h01, {30'd0, vecs[i].sel});
      cfg_write(8'h02, {28'd0, vecs[i].op});
      cfg_write(8'h03, {16'd0, vecs[i].k});
      @(negedge clk_in);
      check(vecs[i].name, out_w, vecs[i].exp);
    end

    // Addressing: foreign tile, address 0 and unmapped index are all ignored.
    s0 = 16'h0010;
    cfg_write(8'h01, 32'd0);
    cfg_write(8'h02, 32'd0);
    cfg_write(8'h03, 32'd3);
    @(negedge clk_in);
    check("addr_setup", out_w, 16'h0010);
    cfg_raw({24'h000001, 8'h02}, 32'd1);
    @(negedge clk_in);
    check("addr_other_tile", out_w, 16'h0010);
    cfg_raw(32'd0, 32'd1);
    @(negedge clk_in);
    check("addr_zero", out_w, 16'h0010);
    cfg_raw({TILE_ID, 8'h05}, 32'd1);
    cfg_raw({24'h000002, 8'h04}, 32'd0);
    @(negedge clk_in);
    check("addr_unmapped", out_w, 16'h0010);

    // Same-edge write: capture uses the old K on the write edge.
    cfg_write(8'h02, 32'd1);
    cfg_write(8'h03, 32'd1);
    @(negedge clk_in);
    check("same_edge_setup", out_w, 16'h0011);
    @(negedge clk_in);
    s0 = 16'h0020;
    config_addr_in = {TILE_ID, 8'h03};
    config_data_in = 32'd5;
    @(negedge clk_in);
    config_addr_in = 32'd0;
    config_data_in = 32'd0;
    check("same_edge_old_k", out_w, 16'h0021);
    @(negedge clk_in);
    check("same_edge_new_k", out_w, 16'h0025);

    // Asynchronous reset mid-cycle wipes config and output.
    #2 reset_in = 1'b0;
    #1;
    check("midrun_reset_async", out_w, 16'h0000);
    @(negedge clk_in);
    reset_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("midrun_config_lost", out_w, 16'h0000);
    s0 = 16'hA5C3;
    cfg_write(8'h04, 32'd1);
    check("midrun_reconfig", out_w, 16'hA5C3);

`ifdef JTAG_BYPASS_EN
    tms = 1'b0;
    tdi = 1'b1; tck_pulse();
    check("jtag_shift1", {15'd0, tdo}, 16'd1);
    tdi = 1'b0; tck_pulse();
    check("jtag_shift0", {15'd0, tdo}, 16'd0);
    tdi = 1'b1; tck_pulse();
    check("jtag_shift1b", {15'd0, tdo}, 16'd1);
    tms = 1'b1; tdi = 1'b0; tck_pulse();
    check("jtag_hold", {15'd0, tdo}, 16'd1);
    trst_n = 1'b0;
    #1;
    check("jtag_trst", {15'd0, tdo}, 16'd0);
    trst_n = 1'b1;
`else
    tms = 1'b0;
    tdi = 1'b1; tck_pulse();
    check("jtag_off_a", {15'd0, tdo}, 16'd0);
    tdi = 1'b0; tck_pulse();
    tdi = 1'b1; tck_pulse();
    check("jtag_off_b", {15'd0, tdo}, 16'd0);
`endif
    check("jtag_no_datapath_effect", out_w, 16'hA5C3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
